// File: rtl/qr_vec_serializer.sv
// qr_vec_serializer: captures an N-element column vector on start, then streams
// its elements one per accepted beat over a valid/ready interface, in forward
// or reverse index order.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   start, reverse        - capture request and order select (sampled in IDLE)
//   vec_in                - packed vector, element k at [k*WIDTH +: WIDTH]
//   out_data/out_idx      - current element and its index
//   out_valid/out_ready   - stream handshake
//   out_last              - final beat of the vector
//   busy, done            - streaming in progress / one-cycle completion pulse
module qr_vec_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 3,
  localparam int unsigned IW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               reverse,
  input  logic [N*WIDTH-1:0] vec_in,
  output logic [WIDTH-1:0]   out_data,
  output logic [IW-1:0]      out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [IW-1:0] CNT_MAX = IW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [N-1:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic                        rev_q, rev_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic                        done_q, done_d;

  logic [IW-1:0]               idx;
  logic                        cnt_last;

  // Element index for the current beat and final-beat detect.
  always_comb begin
    idx      = rev_q ? (CNT_MAX - cnt_q) : cnt_q;
    cnt_last = (cnt_q == CNT_MAX);
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    rev_d    = rev_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = vec_in;
          rev_d    = reverse;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      rev_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rev_q    <= rev_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Outputs decoded from registered state only; data path zeroed outside SEND.
  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_idx   = (state_q == SEND) ? idx : '0;
    out_data  = (state_q == SEND) ? shadow_q[idx] : '0;
    out_last  = (state_q == SEND) && cnt_last;
    done      = done_q;
  end

endmodule

// File: tb/tb_qr_vec_serializer.sv
// Testbench for qr_vec_serializer: an N=3/WIDTH=16 instance for directed cases
// and an N=8/WIDTH=12 instance for randomized order/backpressure sweeps.
module tb_qr_vec_serializer;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void chk(input string tag, input logic ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endfunction

  logic clk = 1'b0;
  logic reset;

  // Instance A: N=3, WIDTH=16
  logic        start_a, rev_a, ready_a;
  logic [47:0] vec_a;
  logic [15:0] data_a;
  logic [1:0]  idx_a;
  logic        valid_a, last_a, busy_a, done_a;

  // Instance B: N=8, WIDTH=12
  logic        start_b, rev_b, ready_b;
  logic [95:0] vec_b;
  logic [11:0] data_b;
  logic [2:0]  idx_b;
  logic        valid_b, last_b, busy_b, done_b;

  always #5 clk = ~clk;

  qr_vec_serializer #(.WIDTH(16), .N(3)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .reverse(rev_a), .vec_in(vec_a),
    .out_data(data_a), .out_idx(idx_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  qr_vec_serializer #(.WIDTH(12), .N(8)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .reverse(rev_b), .vec_in(vec_b),
    .out_data(data_b), .out_idx(idx_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  // Stream one vector through A. Called at a point after a rising edge.
  task automatic send_a(input logic [47:0] v, input logic rv, input int stall_beat,
                        input int stall_len, input bit poke, input bit chained);
    int          exp_i;
    logic [15:0] exp_d;
    int          hold;
    start_a = 1'b1;
    vec_a   = v;
    rev_a   = rv;
    if (chained) begin
      @(negedge clk);
      chk("a_done_chain", done_a === 1'b1);
      chk("a_valid_in_done", valid_a === 1'b0);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    vec_a   = {$urandom, $urandom};
    rev_a   = ~rv;
    for (int k = 0; k < 3; k++) begin
      exp_i = rv ? (2 - k) : k;
      exp_d = v[exp_i*16 +: 16];
      hold  = (k == stall_beat) ? stall_len : 0;
      for (int s = 0; s <= hold; s++) begin
        ready_a = (s == hold);
        if (poke && k == 1 && s == 0) begin
          start_a = 1'b1;
          vec_a   = {$urandom, $urandom};
          rev_a   = $urandom_range(0, 1);
        end else begin
          start_a = 1'b0;
        end
        @(negedge clk);
        chk("a_valid", valid_a === 1'b1);
        chk("a_idx", idx_a === 2'(exp_i));
        chk("a_data", data_a === exp_d);
        chk("a_last", last_a === 1'(k == 2));
        chk("a_busy", busy_a === 1'b1);
        chk("a_done_early", done_a === 1'b0);
        @(posedge clk); #1;
      end
    end
    ready_a = 1'b1;
    start_a = 1'b0;
  endtask

  // Check the done pulse on A and that it lasts exactly one cycle.
  task automatic check_done_a();
    @(negedge clk);
    chk("a_done", done_a === 1'b1);
    chk("a_busy_at_done", busy_a === 1'b0);
    chk("a_valid_at_done", valid_a === 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("a_done_width", done_a === 1'b0);
    chk("a_idle_valid", valid_a === 1'b0);
  endtask

  // Stream one vector through B with random ready against an expected beat list.
  task automatic send_b(input logic [95:0] v, input logic rv);
    int          exp_i[8];
    logic [11:0] exp_d[8];
    int          pos;
    int          cycles;
    for (int k = 0; k < 8; k++) begin
      exp_i[k] = rv ? (7 - k) : k;
      exp_d[k] = v[exp_i[k]*12 +: 12];
    end
    start_b = 1'b1;
    vec_b   = v;
    rev_b   = rv;
    @(posedge clk); #1;
    start_b = 1'b0;
    vec_b   = {$urandom, $urandom, $urandom};
    pos     = 0;
    cycles  = 0;
    while (pos < 8 && cycles < 200) begin
      ready_b = 1'($urandom_range(0, 1));
      start_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("b_valid", valid_b === 1'b1);
      chk("b_idx", idx_b === 3'(exp_i[pos]));
      chk("b_data", data_b === exp_d[pos]);
      chk("b_last", last_b === 1'(pos == 7));
      chk("b_busy", busy_b === 1'b1);
      chk("b_done_early", done_b === 1'b0);
      if (ready_b) pos++;
      @(posedge clk); #1;
      cycles++;
    end
    start_b = 1'b0;
    ready_b = 1'b1;
    chk("b_beat_count", pos == 8);
    @(negedge clk);
    chk("b_done", done_b === 1'b1);
    chk("b_busy_at_done", busy_b === 1'b0);
    chk("b_valid_at_done", valid_b === 1'b0);
  endtask

  localparam logic [47:0] VEC0 = 48'h0C0C_0B0B_0A0A;

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; rev_a = 1'b0; ready_a = 1'b1; vec_a = '0;
    start_b = 1'b0; rev_b = 1'b0; ready_b = 1'b1; vec_b = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", valid_a === 1'b0);
    chk("rst_data", data_a === 16'h0);
    chk("rst_idx", idx_a === 2'h0);
    chk("rst_last", last_a === 1'b0);
    chk("rst_busy", busy_a === 1'b0);
    chk("rst_done", done_a === 1'b0);
    chk("rst_b_valid", valid_b === 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Forward, reverse, stalled, ignored start, then start in the done cycle
    send_a(VEC0, 1'b0, -1, 0, 1'b0, 1'b0);
    check_done_a();
    send_a(VEC0, 1'b1, -1, 0, 1'b0, 1'b0);
    check_done_a();
    send_a(VEC0, 1'b0, 1, 3, 1'b0, 1'b0);
    check_done_a();
    send_a({$urandom, $urandom}, 1'b0, -1, 0, 1'b1, 1'b0);
    send_a({$urandom, $urandom}, 1'b1, 2, 2, 1'b0, 1'b1);
    check_done_a();

    // Reset after beat 0 discards the vector with no done
    start_a = 1'b1; vec_a = VEC0; rev_a = 1'b0; ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("mid_beat0_idx", idx_a === 2'h0);
    chk("mid_beat0_data", data_a === 16'h0A0A);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", valid_a === 1'b0);
    chk("mid_rst_data", data_a === 16'h0);
    chk("mid_rst_idx", idx_a === 2'h0);
    chk("mid_rst_busy", busy_a === 1'b0);
    chk("mid_rst_done", done_a === 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_no_done", done_a === 1'b0);
    send_a(VEC0, 1'b0, -1, 0, 1'b0, 1'b0);
    check_done_a();

    // Reset and start together: reset wins
    reset = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start_a = 1'b0;
    @(negedge clk);
    chk("rst_start_valid", valid_a === 1'b0);
    chk("rst_start_busy", busy_a === 1'b0);

    // Randomized sweep on the N=8 instance
    for (int i = 0; i < 6; i++) begin
      send_b({$urandom, $urandom, $urandom}, 1'(i % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
